// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO; frames go out back-to-back.
// Define UART_TX_PARITY_EN to add one parity bit per frame.
module uart_tx_fifo #(
    parameter int CLK_FREQUENCY  = 66_000_000,
    parameter int UART_FREQUENCY = 921_600,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 16,
    localparam int AW            = $clog2(FIFO_DEPTH)
) (
    input  logic                 user_clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 parity_odd,
    output logic                 tx_bit,
    output logic                 busy,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          fifo_count,
    output logic                 overflow
);

    localparam int TICKS = CLK_FREQUENCY / UART_FREQUENCY;
    localparam logic [15:0] TICK_LAST = 16'(TICKS - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic [AW:0]          count_d;
    logic                 ovf_q;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    state_e               state_q;
    state_e               state_d;
    logic [15:0]          tick_q;
    logic [15:0]          tick_d;
    logic [2:0]           bit_q;
    logic [2:0]           bit_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 tick_last;

`ifdef UART_TX_PARITY_EN
    logic                 par_q;
    logic                 par_d;
`else
    logic                 unused_parity;
    assign unused_parity = parity_odd;
`endif

    assign full       = (count_q == DEPTH);
    assign empty      = (count_q == '0);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign tx_bit     = tx_q;
    assign busy       = busy_q;
    assign push       = wr_en && !full;
    assign head       = mem_q[rd_ptr_q];
    assign tick_last  = (tick_q == TICK_LAST);

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge user_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            if (wr_en && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_last) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_last) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick_last) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_last) begin
                    tick_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A pop restarts bit timing for the freshly loaded character.
        if (pop) begin
            shift_d = head;
            tick_d  = '0;
`ifdef UART_TX_PARITY_EN
            par_d   = (^head) ^ parity_odd;
`endif
        end
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: two instances (8N1 depth 4, 7-bit
// two-stop depth 4) at 16 clocks per bit.
module tb_uart_tx_fifo;

    localparam int TPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FLEN_A = (1 + 8 + P + 1) * TPB;
    localparam int FLEN_B = (1 + 7 + P + 2) * TPB;

    logic       user_clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       wr_en_a = 1'b0;
    logic [7:0] wr_data_a = '0;
    logic       po_a = 1'b0;
    logic       tx_a, busy_a, full_a, empty_a, ovf_a;
    logic [2:0] cnt_a;

    logic       wr_en_b = 1'b0;
    logic [6:0] wr_data_b = '0;
    logic       po_b = 1'b0;
    logic       tx_b, busy_b, full_b, empty_b, ovf_b;
    logic [2:0] cnt_b;

    always #5 user_clk = ~user_clk;

    uart_tx_fifo #(
        .CLK_FREQUENCY(16), .UART_FREQUENCY(1),
        .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_a (
        .user_clk(user_clk), .rst_n(rst_n),
        .wr_en(wr_en_a), .wr_data(wr_data_a), .parity_odd(po_a),
        .tx_bit(tx_a), .busy(busy_a), .full(full_a), .empty(empty_a),
        .fifo_count(cnt_a), .overflow(ovf_a)
    );

    uart_tx_fifo #(
        .CLK_FREQUENCY(16), .UART_FREQUENCY(1),
        .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_b (
        .user_clk(user_clk), .rst_n(rst_n),
        .wr_en(wr_en_b), .wr_data(wr_data_b), .parity_odd(po_b),
        .tx_bit(tx_b), .busy(busy_b), .full(full_b), .empty(empty_b),
        .fifo_count(cnt_b), .overflow(ovf_b)
    );

    int n_pass = 0;
    int n_chk = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic tx_of(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic empty_of(input int sel);
        return (sel != 0) ? empty_b : empty_a;
    endfunction
    function automatic int cnt_of(input int sel);
        return (sel != 0) ? int'(cnt_b) : int'(cnt_a);
    endfunction

    // Expected line level per frame f and bit slot s.
    logic [7:0] exp_d [8];
    logic       exp_p [8];

    function automatic logic exp_bit(input int sel, input int f, input int s);
        int db;
        db = (sel != 0) ? 7 : 8;
        if (s == 0) return 1'b0;
        if (s <= db) return exp_d[f][s-1];
        if (P == 1 && s == db + 1) return exp_p[f];
        return 1'b1;
    endfunction

    int m_ok, m_errs, m_busy, m_emp_before, m_emp_after;
    int m_busy_after, m_tx_after;

    task automatic monitor(input int sel, input int nfr);
        int flen;
        int k;
        flen = (sel != 0) ? FLEN_B : FLEN_A;
        k = 0;
        m_errs = 0;
        m_busy = 0;
        m_emp_before = -1;
        m_emp_after = -1;
        m_busy_after = -1;
        m_tx_after = -1;
        @(negedge user_clk);
        while (!busy_of(sel) && k < 20) begin
            @(negedge user_clk);
            k++;
        end
        m_ok = int'(busy_of(sel));
        if (m_ok == 0) return;
        for (int c = 0; c < nfr * flen; c++) begin
            if (c > 0) @(negedge user_clk);
            if (tx_of(sel) !== exp_bit(sel, c / flen, (c % flen) / TPB))
                m_errs++;
            if (busy_of(sel)) m_busy++;
            if (c == (nfr - 1) * flen - 1) m_emp_before = int'(empty_of(sel));
            if (c == (nfr - 1) * flen) m_emp_after = int'(empty_of(sel));
        end
        @(negedge user_clk);
        m_busy_after = int'(busy_of(sel));
        m_tx_after = int'(tx_of(sel));
    endtask

    task automatic send_one(input int sel, input logic [7:0] d,
                            input logic po);
        @(negedge user_clk);
        if (sel != 0) begin
            wr_en_b = 1'b1; wr_data_b = d[6:0]; po_b = po;
        end else begin
            wr_en_a = 1'b1; wr_data_a = d; po_a = po;
        end
        @(negedge user_clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        check("count after write", cnt_of(sel), 1);
        check("busy before pop", int'(busy_of(sel)), 0);
        @(negedge user_clk);
        check("count after pop", cnt_of(sel), 0);
        check("busy after pop", int'(busy_of(sel)), 1);
        check("tx start", int'(tx_of(sel)), 0);
    endtask

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] data;
        logic       po;
        logic       exp_par;
    } vec_t;

    vec_t vecs [4];

    task automatic run_vec(input vec_t v);
        int flen;
        flen = (v.sel != 0) ? FLEN_B : FLEN_A;
        exp_d[0] = v.data;
        exp_p[0] = v.exp_par;
        fork
            send_one(v.sel, v.data, v.po);
            monitor(v.sel, 1);
        join
        check({v.name, " busy rise"}, m_ok, 1);
        check({v.name, " line bits"}, m_errs, 0);
        check({v.name, " busy length"}, m_busy, flen);
        check({v.name, " busy after"}, m_busy_after, 0);
        check({v.name, " tx after"}, m_tx_after, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        vecs[0] = '{"A5 8N1",      0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{"55 7b even",  1, 8'h55, 1'b0, 1'b0};
        vecs[2] = '{"55 7b odd",   1, 8'h55, 1'b1, 1'b1};
        vecs[3] = '{"3C 8b odd",   0, 8'h3C, 1'b1, 1'b1};

        #12;
        check("reset tx", int'(tx_a), 1);
        check("reset busy", int'(busy_a), 0);
        check("reset full", int'(full_a), 0);
        check("reset empty", int'(empty_a), 1);
        check("reset count", int'(cnt_a), 0);
        check("reset overflow", int'(ovf_a), 0);
        check("reset tx b", int'(tx_b), 1);
        @(negedge user_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge user_clk);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        po_a = 1'b0;
        exp_d[0] = 8'h01; exp_p[0] = 1'b1;
        exp_d[1] = 8'h02; exp_p[1] = 1'b1;
        exp_d[2] = 8'h03; exp_p[2] = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge user_clk);
                    wr_en_a = 1'b1;
                    wr_data_a = 8'(i + 1);
                end
                @(negedge user_clk);
                wr_en_a = 1'b0;
            end
            monitor(0, 3);
        join
        check("b2b busy rise", m_ok, 1);
        check("b2b line bits", m_errs, 0);
        check("b2b busy length", m_busy, 3 * FLEN_A);
        check("b2b empty before third pop", m_emp_before, 0);
        check("b2b empty after third pop", m_emp_after, 1);
        check("b2b busy after", m_busy_after, 0);

        exp_d[0] = 8'h10; exp_p[0] = 1'b1;
        exp_d[1] = 8'h11; exp_p[1] = 1'b0;
        exp_d[2] = 8'h12; exp_p[2] = 1'b0;
        exp_d[3] = 8'h13; exp_p[3] = 1'b1;
        exp_d[4] = 8'h14; exp_p[4] = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge user_clk);
                    if (i == 5) begin
                        check("ovf full before", int'(full_a), 1);
                        check("ovf flag before", int'(ovf_a), 0);
                    end
                    wr_en_a = 1'b1;
                    wr_data_a = 8'(8'h10 + i);
                end
                @(negedge user_clk);
                wr_en_a = 1'b0;
                check("ovf flag set", int'(ovf_a), 1);
                check("ovf full", int'(full_a), 1);
                check("ovf count", int'(cnt_a), 4);
            end
            monitor(0, 5);
        join
        check("ovf busy rise", m_ok, 1);
        check("ovf line bits", m_errs, 0);
        check("ovf five frames", m_busy, 5 * FLEN_A);
        check("ovf busy after", m_busy_after, 0);
        check("ovf sticky", int'(ovf_a), 1);

        // Reset in the middle of data bit 3 of a 0x00 frame.
        @(negedge user_clk);
        wr_en_a = 1'b1;
        wr_data_a = 8'h00;
        @(negedge user_clk);
        wr_en_a = 1'b0;
        @(negedge user_clk);
        check("rst frame started", int'(busy_a), 1);
        wr_en_a = 1'b1;
        wr_data_a = 8'hAA;
        @(negedge user_clk);
        wr_data_a = 8'hBB;
        @(negedge user_clk);
        wr_en_a = 1'b0;
        repeat (70) @(negedge user_clk);
        check("rst pre tx", int'(tx_a), 0);
        check("rst pre count", int'(cnt_a), 2);
        #1 rst_n = 1'b0;
        #1;
        check("rst async tx", int'(tx_a), 1);
        check("rst async busy", int'(busy_a), 0);
        check("rst async count", int'(cnt_a), 0);
        check("rst async overflow", int'(ovf_a), 0);
        check("rst async empty", int'(empty_a), 1);
        @(negedge user_clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge user_clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("idle after reset", bad, 0);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO and configurable frame format. It replaces the single-byte transmitter. Upstream logic can queue up to FIFO_DEPTH characters with a simple write strobe. The block serialises them back-to-back onto the line with no idle gap between queued frames.

## Interface
- CLK_FREQUENCY, 66_000_000: user_clk frequency in Hz.
- UART_FREQUENCY, 921_600: baud rate. TICKS_PER_BIT = CLK_FREQUENCY / UART_FREQUENCY (integer division); legal range 2..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; power of two, ≥2. AW = $clog2(FIFO_DEPTH).
- user_clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wr_en  in  1  push wr_data into the FIFO this cycle.
- wr_data  in  DATA_BITS  character to queue.
- parity_odd  in  1  1 = odd parity, 0 = even parity; ignored unless UART_TX_PARITY_EN is defined.
- tx_bit  out  1  serial line, idle high.
- busy  out  1  high while a frame is on the line (START through last STOP tick).
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- fifo_count  out  AW+1  current FIFO occupancy.
- overflow  out  1  sticky; set when wr_en is asserted while full=1.

## Operation
- Reset values: tx_bit=1, busy=0, full=0, empty=1, fifo_count=0, overflow=0. FIFO pointers, shift register, tick counter and bit counter are all 0. State is IDLE.
- FIFO: circular buffer with registered read/write pointers.
  - A write with full=0 stores the character and increments fifo_count.
  - A write with full=1 is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_bit=1. When empty=0, pop the head entry into the shift register, go to START, and set tx_bit=0 on the same edge.
  - START: hold 0 for TICKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out LSB first, one bit per TICKS_PER_BIT cycles. Bit counter runs 0..DATA_BITS-1. After the last bit, go to PARITY if enabled, otherwise STOP.
  - PARITY: send XOR of the data bits, XORed with parity_odd. parity_odd is sampled at pop time. Lasts TICKS_PER_BIT cycles.
  - STOP: tx_bit=1 for STOP_BITS×TICKS_PER_BIT cycles. On the final tick, if empty=0, pop and go directly to START. Otherwise go to IDLE.
- Tick counter: 16 bits. Counts 0..TICKS_PER_BIT-1, wraps to 0 at each bit boundary, and is cleared on every pop.
- tx_bit and busy are registered outputs with no combinational path from inputs.
- Reset mid-frame: tx_bit returns to 1 immediately (asynchronously), the FIFO is flushed, and overflow is cleared.

## Timing
- Write at edge N into an idle, empty block: fifo_count=1 after edge N; tx_bit=0 and busy=1 after edge N+1; fifo_count returns to 0 after edge N+1.
- Frame length in cycles: (1 + DATA_BITS + P + STOP_BITS) × TICKS_PER_BIT, where P=1 with parity enabled, else 0.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle; busy stays high throughout.
- full, empty and fifo_count update on the edge after the write or pop.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is compiled in and every frame carries one parity bit between the data bits and the stop bits.
- UART_TX_PARITY_EN undefined: the PARITY state and its logic are absent, DATA goes directly to STOP, and parity_odd is unused.

## Test plan
All scenarios use CLK_FREQUENCY=16, UART_FREQUENCY=1 (TICKS_PER_BIT=16).
- Single frame, DATA_BITS=8, STOP_BITS=1, no parity. Write 8'hA5 when idle → tx_bit is 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles. busy is high for exactly 160 cycles.
- Parity enabled, DATA_BITS=7, STOP_BITS=2. Write 7'h55 with parity_odd=0, then with parity_odd=1 → parity bit is 0 and then 1. Each frame lasts 176 cycles.
- Back-to-back. Write 8'h01, 8'h02, 8'h03 on consecutive cycles → three contiguous 160-cycle frames with no idle cycles between them. busy stays high for 480 cycles; empty rises one cycle after the third pop.
- Overflow, FIFO_DEPTH=4. Write 6 characters in consecutive cycles while the first is transmitting → the first 5 are accepted (1 popped plus 4 queued), the 6th is dropped, overflow=1, full=1, and 5 frames are sent.
- Reset mid-frame. Assert rst_n=0 during data bit 3 → tx_bit=1, busy=0, fifo_count=0 and overflow=0 immediately. After release, the line stays idle until the next write.
